// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: entry layout, flag bundle
// and the run/halted/timeout state encoding.
package trace_pkg;

    localparam int TR_DATA_W = 16;
    localparam int TR_REG_W  = 4;
    localparam int TR_FLAG_W = 4;

    typedef enum logic [1:0] {
        STATE_RUN     = 2'd0,
        STATE_HALTED  = 2'd1,
        STATE_TIMEOUT = 2'd2
    } state_e;

    typedef struct packed {
        logic halt;
        logic regwr;
        logic memrd;
        logic memwr;
    } flags_t;

    typedef struct packed {
        flags_t                flags;
        logic [TR_REG_W-1:0]   rd;
        logic [TR_DATA_W-1:0]  pc;
        logic [TR_DATA_W-1:0]  wdata;
        logic [TR_DATA_W-1:0]  addr;
        logic [TR_DATA_W-1:0]  mdata;
    } entry_t;

    function automatic int entry_width(int dw, int rw);
        return TR_FLAG_W + rw + 4 * dw;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular trace storage with valid/ready pop and a selectable
// full policy: drop the newest entry or overwrite the oldest.
module trace_fifo #(
    parameter int W         = 72,
    parameter int DEPTH     = 16,
    parameter int WRAP_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [W-1:0]             data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ovf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full, empty, pop_ok, wr_en, ovf;

    assign full   = cnt_q == CW'(DEPTH);
    assign empty  = cnt_q == '0;
    assign pop_ok = pop_i & ~empty;

    // Pointer/count update; a pop frees a slot for a same-cycle push.
    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        wr_en = 1'b0;
        ovf   = 1'b0;
        if (pop_ok) begin
            rp_d = rp_q + AW'(1);
        end
        if (push_i) begin
            if (!full || pop_ok) begin
                wr_en = 1'b1;
                wp_d  = wp_q + AW'(1);
            end else if (WRAP_MODE != 0) begin
                wr_en = 1'b1;
                wp_d  = wp_q + AW'(1);
                rp_d  = rp_q + AW'(1);
                ovf   = 1'b1;
            end else begin
                ovf   = 1'b1;
            end
        end
        if (wr_en && !pop_ok && !ovf) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!wr_en && pop_ok) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Storage is left uncleared on reset; rd data is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wp_q] <= data_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid_o = ~empty;
    assign data_o  = empty ? '0 : mem_q[rp_q];
    assign count_o = cnt_q;
    assign ovf_o   = ovf;

endmodule

// File: rtl/commit_trace_buffer.sv
// Retire-event trace monitor: packs commit events into a trace FIFO,
// counts cycles/instructions, halts or times out. Option: TRACE_LOAD_EN.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_W      = 4,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 32,
    parameter int WRAP_MODE  = 0,
    parameter int MAX_CYCLES = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                cap_en,
    input  logic [DATA_W-1:0]                   ev_pc,
    input  logic                                ev_regwr,
    input  logic [REG_W-1:0]                    ev_reg,
    input  logic [DATA_W-1:0]                   ev_wdata,
    input  logic                                ev_memrd,
    input  logic                                ev_memwr,
    input  logic [DATA_W-1:0]                   ev_addr,
    input  logic [DATA_W-1:0]                   ev_mdata,
    input  logic                                ev_halt,
    output logic                                rd_valid,
    input  logic                                rd_ready,
    output logic [TR_FLAG_W+REG_W+4*DATA_W-1:0] rd_data,
    output logic [$clog2(DEPTH):0]              count,
    output logic                                overflow,
    output logic [CNT_W-1:0]                    cycle_cnt,
    output logic [CNT_W-1:0]                    inst_cnt,
    output logic                                halted,
    output logic                                timeout
);

    localparam int ENTRY_W = TR_FLAG_W + REG_W + 4 * DATA_W;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cyc_q, cyc_d;
    logic [CNT_W-1:0]     inst_q, inst_d;
    logic                 ovf_q, ovf_d;
    logic                 run, memrd_f, commit, push, fifo_ovf;
    flags_t               flags;
    logic [ENTRY_W-1:0]   entry;

    assign run = state_q == STATE_RUN;

`ifdef TRACE_LOAD_EN
    assign memrd_f = ev_memrd;
`else
    assign memrd_f = ev_memrd & 1'b0;
`endif

    assign flags  = '{halt: ev_halt, regwr: ev_regwr,
                      memrd: memrd_f, memwr: ev_memwr};
    assign entry  = {flags, ev_reg, ev_pc, ev_wdata, ev_addr, ev_mdata};
    assign commit = ev_halt | ev_regwr | ev_memwr;
    assign push   = run & cap_en & (|flags);

    trace_fifo #(
        .W         (ENTRY_W),
        .DEPTH     (DEPTH),
        .WRAP_MODE (WRAP_MODE)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (entry),
        .pop_i   (rd_ready),
        .valid_o (rd_valid),
        .data_o  (rd_data),
        .count_o (count),
        .ovf_o   (fifo_ovf)
    );

    // Saturating counters and run/halted/timeout transitions.
    always_comb begin
        cyc_d   = cyc_q;
        inst_d  = inst_q;
        state_d = state_q;
        ovf_d   = ovf_q | fifo_ovf;
        if (run) begin
            if (cyc_q != '1) begin
                cyc_d = cyc_q + CNT_W'(1);
            end
            if (commit && inst_q != '1) begin
                inst_d = inst_q + CNT_W'(1);
            end
            if (ev_halt) begin
                state_d = STATE_HALTED;
            end else if (MAX_CYCLES != 0 &&
                         cyc_q == CNT_W'(MAX_CYCLES - 1)) begin
                state_d = STATE_TIMEOUT;
            end
        end
    end

    // State, counters and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= STATE_RUN;
            cyc_q   <= '0;
            inst_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            inst_q  <= inst_d;
            ovf_q   <= ovf_d;
        end
    end

    assign overflow  = ovf_q;
    assign cycle_cnt = cyc_q;
    assign inst_cnt  = inst_q;
    assign halted    = state_q == STATE_HALTED;
    assign timeout   = state_q == STATE_TIMEOUT;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench: three DUT configurations share stimulus; a queue
// model per DUT predicts contents, counters and flags.
module tb_commit_trace_buffer;

    localparam int DW    = 16;
    localparam int RW    = 4;
    localparam int DEPTH = 16;
    localparam int CW    = 32;
    localparam int EW    = 4 + RW + 4 * DW;
    localparam int NW    = $clog2(DEPTH) + 1;
`ifdef TRACE_LOAD_EN
    localparam bit LOADS = 1'b1;
`else
    localparam bit LOADS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cap_en = 1'b0;
    logic [DW-1:0] ev_pc = '0;
    logic          ev_regwr = 1'b0;
    logic [RW-1:0] ev_reg = '0;
    logic [DW-1:0] ev_wdata = '0;
    logic          ev_memrd = 1'b0;
    logic          ev_memwr = 1'b0;
    logic [DW-1:0] ev_addr = '0;
    logic [DW-1:0] ev_mdata = '0;
    logic          ev_halt = 1'b0;
    logic          rd_ready = 1'b0;

    logic [2:0]             rv, ovf, hlt, tmo;
    logic [2:0][EW-1:0]     rdd;
    logic [2:0][NW-1:0]     cnt;
    logic [2:0][CW-1:0]     cyc, ins;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(.DEPTH(DEPTH), .WRAP_MODE(0), .MAX_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .ev_pc(ev_pc),
        .ev_regwr(ev_regwr), .ev_reg(ev_reg), .ev_wdata(ev_wdata),
        .ev_memrd(ev_memrd), .ev_memwr(ev_memwr), .ev_addr(ev_addr),
        .ev_mdata(ev_mdata), .ev_halt(ev_halt), .rd_valid(rv[0]),
        .rd_ready(rd_ready), .rd_data(rdd[0]), .count(cnt[0]),
        .overflow(ovf[0]), .cycle_cnt(cyc[0]), .inst_cnt(ins[0]),
        .halted(hlt[0]), .timeout(tmo[0]));

    commit_trace_buffer #(.DEPTH(DEPTH), .WRAP_MODE(1), .MAX_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .ev_pc(ev_pc),
        .ev_regwr(ev_regwr), .ev_reg(ev_reg), .ev_wdata(ev_wdata),
        .ev_memrd(ev_memrd), .ev_memwr(ev_memwr), .ev_addr(ev_addr),
        .ev_mdata(ev_mdata), .ev_halt(ev_halt), .rd_valid(rv[1]),
        .rd_ready(rd_ready), .rd_data(rdd[1]), .count(cnt[1]),
        .overflow(ovf[1]), .cycle_cnt(cyc[1]), .inst_cnt(ins[1]),
        .halted(hlt[1]), .timeout(tmo[1]));

    commit_trace_buffer #(.DEPTH(DEPTH), .WRAP_MODE(0), .MAX_CYCLES(50)) u2 (
        .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .ev_pc(ev_pc),
        .ev_regwr(ev_regwr), .ev_reg(ev_reg), .ev_wdata(ev_wdata),
        .ev_memrd(ev_memrd), .ev_memwr(ev_memwr), .ev_addr(ev_addr),
        .ev_mdata(ev_mdata), .ev_halt(ev_halt), .rd_valid(rv[2]),
        .rd_ready(rd_ready), .rd_data(rdd[2]), .count(cnt[2]),
        .overflow(ovf[2]), .cycle_cnt(cyc[2]), .inst_cnt(ins[2]),
        .halted(hlt[2]), .timeout(tmo[2]));

    // Reference model: a queue of expected entries per DUT.
    logic [EW-1:0] mq [3][$];
    int            md [3] = '{0, 1, 0};
    longint        mx [3] = '{0, 0, 50};
    longint        mcyc [3];
    longint        mins [3];
    bit            movf [3];
    int            mst  [3];   // 0 running, 1 halted, 2 timed out

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_step(int k);
        logic [EW-1:0] e;
        bit run;
        if (!rst_n) begin
            mq[k].delete();
            mcyc[k] = 0;
            mins[k] = 0;
            movf[k] = 1'b0;
            mst[k]  = 0;
        end else begin
            run = (mst[k] == 0);
            if (mq[k].size() > 0 && rd_ready) void'(mq[k].pop_front());
            if (run && cap_en &&
                (ev_regwr || ev_memwr || ev_halt || (LOADS && ev_memrd))) begin
                e = {ev_halt, ev_regwr, LOADS & ev_memrd, ev_memwr,
                     ev_reg, ev_pc, ev_wdata, ev_addr, ev_mdata};
                if (mq[k].size() < DEPTH) begin
                    mq[k].push_back(e);
                end else begin
                    movf[k] = 1'b1;
                    if (md[k] == 1) begin
                        void'(mq[k].pop_front());
                        mq[k].push_back(e);
                    end
                end
            end
            if (run) begin
                if (mcyc[k] < 64'hFFFF_FFFF) mcyc[k]++;
                if ((ev_regwr || ev_memwr || ev_halt) &&
                    mins[k] < 64'hFFFF_FFFF) mins[k]++;
                if (ev_halt) mst[k] = 1;
                else if (mx[k] != 0 && mcyc[k] == mx[k]) mst[k] = 2;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_step(k);
    end

    // Monitor: compare every DUT output against the model each cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d.rd_valid", k), 128'(rv[k]),
                128'(mq[k].size() > 0));
            chk($sformatf("u%0d.count", k), 128'(cnt[k]),
                128'(mq[k].size()));
            if (mq[k].size() > 0)
                chk($sformatf("u%0d.rd_data", k), 128'(rdd[k]),
                    128'(mq[k][0]));
            else
                chk($sformatf("u%0d.rd_data_empty", k), 128'(rdd[k]), 128'(0));
            chk($sformatf("u%0d.overflow", k), 128'(ovf[k]), 128'(movf[k]));
            chk($sformatf("u%0d.halted", k), 128'(hlt[k]),
                128'(mst[k] == 1));
            chk($sformatf("u%0d.timeout", k), 128'(tmo[k]),
                128'(mst[k] == 2));
            chk($sformatf("u%0d.cycle_cnt", k), 128'(cyc[k]),
                128'(mcyc[k]));
            chk($sformatf("u%0d.inst_cnt", k), 128'(ins[k]),
                128'(mins[k]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ev_pc = '0; ev_regwr = 0; ev_reg = '0; ev_wdata = '0;
        ev_memrd = 0; ev_memwr = 0; ev_addr = '0; ev_mdata = '0;
        ev_halt = 0;
    endtask

    task automatic rand_ev(int halt_pct);
        ev_pc    = DW'($urandom);
        ev_regwr = 1'($urandom);
        ev_reg   = RW'($urandom);
        ev_wdata = DW'($urandom);
        ev_memrd = 1'($urandom);
        ev_memwr = ($urandom_range(0, 3) == 0);
        ev_addr  = DW'($urandom);
        ev_mdata = DW'($urandom);
        ev_halt  = ($urandom_range(0, 99) < halt_pct);
        cap_en   = ($urandom_range(0, 9) != 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        rand_ev(30);
        rd_ready = 1'($urandom);
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst.u%0d.count", k), 128'(cnt[k]), 128'(0));
            chk($sformatf("rst.u%0d.valid", k), 128'(rv[k]), 128'(0));
            chk($sformatf("rst.u%0d.cycle", k), 128'(cyc[k]), 128'(0));
            chk($sformatf("rst.u%0d.flags", k),
                128'({ovf[k], hlt[k], tmo[k]}), 128'(0));
        end
        idle();
        cap_en = 1;
        rd_ready = 0;
        rst_n = 1;
    endtask

    task automatic push_pc(int i);
        idle();
        ev_regwr = 1;
        ev_pc    = DW'(i);
        ev_reg   = RW'(i);
        ev_wdata = DW'(i);
    endtask

    initial begin
        #1;
        do_reset();

        // Directed: regwr, store, combined regwr+store.
        idle(); ev_regwr = 1; ev_reg = 4'd3; ev_pc = 16'h0004;
        ev_wdata = 16'h00AA;
        tick();
        idle(); ev_memwr = 1; ev_pc = 16'h0006; ev_addr = 16'h0010;
        ev_mdata = 16'h1234;
        tick();
        idle(); ev_regwr = 1; ev_memwr = 1; ev_reg = 4'd5;
        ev_pc = 16'h0008; ev_wdata = 16'h0055; ev_addr = 16'h0020;
        ev_mdata = 16'h0077;
        tick();
        idle();
        chk("dir.count", 128'(cnt[0]), 128'(3));
        chk("dir.inst_cnt", 128'(ins[0]), 128'(3));
        chk("dir.e0", 128'(rdd[0]),
            128'({4'b0100, 4'h3, 16'h0004, 16'h00AA, 16'h0, 16'h0}));
        rd_ready = 1;
        tick();
        chk("dir.e1", 128'(rdd[0]),
            128'({4'b0001, 4'h0, 16'h0006, 16'h0, 16'h0010, 16'h1234}));
        tick();
        chk("dir.e2", 128'(rdd[0]),
            128'({4'b0101, 4'h5, 16'h0008, 16'h0055, 16'h0020, 16'h0077}));
        tick();
        chk("dir.empty", 128'(rv[0]), 128'(0));

        // 18 pushes without pop: drop (u0) versus overwrite (u1).
        do_reset();
        for (int i = 0; i < 18; i++) begin
            push_pc(i);
            tick();
        end
        idle();
        chk("full.u0.count", 128'(cnt[0]), 128'(16));
        chk("full.u1.count", 128'(cnt[1]), 128'(16));
        chk("full.u0.ovf", 128'(ovf[0]), 128'(1));
        chk("full.u1.ovf", 128'(ovf[1]), 128'(1));
        chk("full.u0.oldest_pc", 128'(rdd[0][4*DW-1:3*DW]), 128'(0));
        chk("full.u1.oldest_pc", 128'(rdd[1][4*DW-1:3*DW]), 128'(2));
        rd_ready = 1;
        for (int i = 0; i < 15; i++) tick();
        chk("full.u0.last_pc", 128'(rdd[0][4*DW-1:3*DW]), 128'(15));
        chk("full.u1.last_pc", 128'(rdd[1][4*DW-1:3*DW]), 128'(17));
        tick();
        chk("full.drained", 128'(cnt[0]), 128'(0));

        // Full with simultaneous push and pop: no overflow.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            push_pc(i);
            tick();
        end
        push_pc(100);
        rd_ready = 1;
        tick();
        idle();
        rd_ready = 0;
        chk("pp.u0.ovf", 128'(ovf[0]), 128'(0));
        chk("pp.u1.ovf", 128'(ovf[1]), 128'(0));
        chk("pp.u1.count", 128'(cnt[1]), 128'(16));

        // Load-only cycle.
        do_reset();
        idle(); ev_memrd = 1; ev_addr = 16'h0040; ev_mdata = 16'hBEEF;
        tick();
        idle();
        chk("load.count", 128'(cnt[0]), 128'(LOADS ? 1 : 0));
        chk("load.inst_cnt", 128'(ins[0]), 128'(0));

        // Watchdog: u2 times out at 50 cycles.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            rand_ev(0);
            rd_ready = 1'($urandom);
            tick();
        end
        idle();
        chk("wd.u2.timeout", 128'(tmo[2]), 128'(1));
        chk("wd.u2.cycle", 128'(cyc[2]), 128'(50));
        chk("wd.u0.timeout", 128'(tmo[0]), 128'(0));

        // Halt on the tenth cycle after reset release.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            rand_ev(0);
            cap_en = 1;
            rd_ready = 0;
            tick();
        end
        idle(); ev_halt = 1; ev_regwr = 1; ev_pc = 16'h0099;
        tick();
        for (int i = 0; i < 10; i++) begin
            rand_ev(20);
            rd_ready = 1'($urandom);
            tick();
        end
        idle();
        chk("halt.halted", 128'(hlt[0]), 128'(1));
        chk("halt.cycle", 128'(cyc[0]), 128'(10));

        // Long random run with occasional halts and resets.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 120; i++) begin
                rand_ev(2);
                rd_ready = ($urandom_range(0, 2) != 0);
                tick();
            end
        end
        idle();
        rd_ready = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("end.u0.empty", 128'(cnt[0]), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
